// File: rtl/game_pkg.sv
// Shared types and constants for the tug-of-war match controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    PLAY,
    ROUNDEND,
    MATCHOVER
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  localparam int SCORE_W = 3;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter. done is high while the count sits at zero.
module cycle_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // Holds at zero rather than wrapping, so done stays valid until the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/match_sequencer.sv
// Match controller: countdown, play, round hold and match-over sequencing
// with both scores and the winner code kept in registers.
module match_sequencer
  import game_pkg::*;
#(
  parameter int WIN_SCORE        = 5,
  parameter int COUNTDOWN_CYCLES = 4,
  parameter int HOLD_CYCLES      = 3,
  parameter int TIMER_W          = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               p1Win,
  input  logic               p2Win,
  output logic               playEnable,
  output logic               nextRound,
  output logic [SCORE_W-1:0] p1Score,
  output logic [SCORE_W-1:0] p2Score,
  output logic               matchOver,
  output logic [1:0]         winner
);

  localparam logic [TIMER_W-1:0] CD_LOAD   = TIMER_W'(COUNTDOWN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);

  state_t             state;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_done;
  logic               p1_round;
  logic               p2_round;
  logic               match_won;

  assign p1_round  = p1Win & ~p2Win;
  assign p2_round  = p2Win & ~p1Win;
  assign match_won = (p1Score == WIN_S) || (p2Score == WIN_S);

  // The timer loads on the same edge that enters a timed state.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = CD_LOAD;
    case (state)
      IDLE, MATCHOVER: begin
        timer_load = start;
      end
      PLAY: begin
        timer_load  = p1_round | p2_round;
        timer_value = HOLD_LOAD;
      end
      ROUNDEND: begin
        timer_load = timer_done & ~match_won;
      end
      default: ;
    endcase
  end

  cycle_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      p1Score    <= '0;
      p2Score    <= '0;
      playEnable <= 1'b0;
      nextRound  <= 1'b0;
      matchOver  <= 1'b0;
      winner     <= WIN_NONE;
    end else begin
      nextRound <= 1'b0;
      case (state)
        IDLE, MATCHOVER: begin
          if (start) begin
            state     <= COUNTDOWN;
            p1Score   <= '0;
            p2Score   <= '0;
            winner    <= WIN_NONE;
            matchOver <= 1'b0;
          end
        end
        COUNTDOWN: begin
          if (timer_done) begin
            state      <= PLAY;
            playEnable <= 1'b1;
          end
        end
        PLAY: begin
          // A simultaneous pair of pulses is a tie and leaves play running.
          if (p1_round || p2_round) begin
            state      <= ROUNDEND;
            playEnable <= 1'b0;
            if (p1_round) p1Score <= p1Score + 1'b1;
            else          p2Score <= p2Score + 1'b1;
          end
        end
        ROUNDEND: begin
          if (timer_done) begin
            nextRound <= 1'b1;
            if (match_won) begin
              state     <= MATCHOVER;
              matchOver <= 1'b1;
              winner    <= (p1Score == WIN_S) ? WIN_P1 : WIN_P2;
            end else begin
              state <= COUNTDOWN;
            end
          end
        end
        default: begin
          state      <= IDLE;
          playEnable <= 1'b0;
          matchOver  <= 1'b0;
        end
      endcase
    end
  end

endmodule
